log2_max_abs_stream: RTL and testbench
======================================

Name: log2_max_abs_stream

Overview:
- Streaming shared-exponent extractor for MXInt quantisation.
- Computes floor(log2(max |x|)) over one block of BLOCK_BEATS x IN_SIZE elements that arrives over several valid/ready beats, not a single beat.
- Emits one exponent plus a zero-block flag per block.
- Sits between the upstream data FIFO and the mantissa-shift stage of the MXInt cast path.

Parameters:
- IN_SIZE, 4: elements per beat.
- IN_WIDTH, 16: element width in bits.
- BLOCK_BEATS, 4: beats per block (>=1); one exponent is produced per block.
- SIGNED, 1: 1 = elements are two's complement, take abs; 0 = elements are unsigned, no abs.
- OUT_WIDTH, $clog2(IN_WIDTH)+1: exponent output width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  IN_WIDTH x [IN_SIZE-1:0]  unpacked beat of elements.
- data_in_valid  input  1  beat valid.
- data_in_ready  output  1  beat accepted when valid && ready.
- data_out  output  OUT_WIDTH  floor(log2(max |x|)) for the block, zero-extended.
- data_out_zero  output  1  every element of the block was 0.
- data_out_valid  output  1  result valid.
- data_out_ready  input  1  result consumed when valid && ready.

Behaviour:
- Single clock: clk. Reset: rst, asynchronous, active-high. While rst is high, all state clears:
  - beat_cnt=0, acc=0.
  - data_out=0, data_out_zero=0, data_out_valid=0.
- Per beat (combinational):
  - abs_i = SIGNED && x_i[MSB] ? (~x_i+1) : x_i, kept at IN_WIDTH bits.
  - The most-negative value -2^(IN_WIDTH-1) gives abs = 2^(IN_WIDTH-1), interpreted unsigned, so its exponent is IN_WIDTH-1. This is required behaviour; do not saturate.
  - beat_or = OR of all abs_i. An OR suffices because only the leading-one index is needed.
- Accumulation:
  - acc (IN_WIDTH bits) and beat_cnt (0..BLOCK_BEATS-1) update only on an accepted beat.
  - Non-last beat: acc <= acc | beat_or; beat_cnt++.
  - Last beat (beat_cnt==BLOCK_BEATS-1): final = acc | beat_or; acc <= 0; beat_cnt <= 0. On the next edge:
    - data_out <= index of highest set bit of final (0 if final==0).
    - data_out_zero <= (final==0).
    - data_out_valid <= 1.
  - BLOCK_BEATS=1: every accepted beat is a last beat.
- Latency: result is valid on the cycle after the last beat is accepted (1 cycle).
- Output register:
  - Holds data_out and data_out_zero stable while valid && !ready.
  - Clears valid on handshake unless a new result loads in the same cycle. Load wins, so back-to-back results are produced with no bubble.
- Handshake:
  - data_in_ready = (beat_cnt != BLOCK_BEATS-1) || !data_out_valid || data_out_ready.
  - Non-last beats are always accepted, even while a result is stalled.
  - The last beat stalls only when the output is full and not being drained.
  - data_in_ready does not depend on data_in_valid.
- Throughput: one beat per cycle sustained when data_out_ready=1.
- Zero block: data_out=0 with data_out_zero=1. This distinguishes it from a block whose max is 1, which gives data_out=0 with data_out_zero=0.
- Reset mid-block: the partial acc and beat_cnt are discarded. The next accepted beat after reset is beat 0 of a new block.
- data_in_valid low: acc and beat_cnt hold; no timeout and no partial flush.

Test Plan:
- IN_SIZE=4, IN_WIDTH=16, BLOCK_BEATS=4, SIGNED=1:
  - Beats {1,2,3,4},{0,0,5,0},{-7,0,0,0},{0,0,0,2}, data_out_ready=1 → one result, data_out=2, zero=0, valid exactly one cycle after the 4th beat.
- Most negative:
  - One beat contains -32768 (0x8000), all else 0 → data_out=15, zero=0.
  - Same with SIGNED=0 and 0x8000 → data_out=15.
  - With SIGNED=0, 0xFFFF → data_out=15 (no abs applied).
- All-zero block → data_out=0, zero=1. A block whose only nonzero element is 1 → data_out=0, zero=0.
- Backpressure:
  - Hold data_out_ready=0 with continuous valid input. After the first result, beats 0-2 of block 2 are accepted; the last beat of block 2 sees ready=0; the result stays stable.
  - Raise data_out_ready for one cycle → first result consumed; the last beat is accepted in the same cycle; block 2's result appears on the next cycle.
- Streaming with BLOCK_BEATS=1, data_out_ready=1:
  - 8 consecutive beats with max values 1,2,4,...,128 → exponents 0..7, one per cycle, no bubbles.
- Async reset:
  - Assert rst between clock edges after 2 beats of a block → outputs clear immediately, without waiting for an edge.
  - After release, 4 beats of max 0x0100 → data_out=8. The earlier partial beats must not contribute.

Source files
------------

// File: rtl/log2_max_abs_stream_if.sv
// Beat stream in, one exponent/zero-flag result out; both sides use valid/ready.
// The design takes the slave side, the producer/consumer the master side.
interface log2_max_abs_stream_if #(
    parameter int IN_SIZE   = 4,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = $clog2(IN_WIDTH) + 1
);
    logic [IN_WIDTH-1:0]  data_in [IN_SIZE];
    logic                 data_in_valid;
    logic                 data_in_ready;
    logic [OUT_WIDTH-1:0] data_out;
    logic                 data_out_zero;
    logic                 data_out_valid;
    logic                 data_out_ready;

    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_zero, data_out_valid
    );

    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_zero, data_out_valid
    );
endinterface

// File: rtl/log2_max_abs_stream.sv
// floor(log2(max |x|)) over a BLOCK_BEATS-beat block; result registered 1 cycle after last beat.
// Non-last beats always accepted; last beat stalls only while an undrained result is held.
module log2_max_abs_stream #(
    parameter int IN_SIZE     = 4,
    parameter int IN_WIDTH    = 16,
    parameter int BLOCK_BEATS = 4,
    parameter int SIGNED      = 1,
    parameter int OUT_WIDTH   = $clog2(IN_WIDTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    log2_max_abs_stream_if.slave   s_if
);
    localparam int CNT_W = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BEATS - 1);

    logic [CNT_W-1:0]     r_beat_cnt;
    logic [IN_WIDTH-1:0]  r_acc;
    logic [IN_WIDTH-1:0]  w_beat_or;
    logic [IN_WIDTH-1:0]  w_final;
    logic [OUT_WIDTH-1:0] w_lead;
    logic                 w_last;
    logic                 w_accept;

    // Only the leading-one position matters, so OR-ing magnitudes is enough.
    // The most-negative input wraps to 2^(IN_WIDTH-1) unsigned, giving IN_WIDTH-1.
    always_comb begin
        w_beat_or = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            if (SIGNED != 0 && s_if.data_in[i][IN_WIDTH-1])
                w_beat_or = w_beat_or | (~s_if.data_in[i] + IN_WIDTH'(1));
            else
                w_beat_or = w_beat_or | s_if.data_in[i];
        end
    end

    assign w_final = r_acc | w_beat_or;

    always_comb begin
        w_lead = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (w_final[i])
                w_lead = OUT_WIDTH'(i);
        end
    end

    assign w_last             = (r_beat_cnt == LAST_CNT);
    assign s_if.data_in_ready = !w_last || !s_if.data_out_valid || s_if.data_out_ready;
    assign w_accept           = s_if.data_in_valid && s_if.data_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt          <= '0;
            r_acc               <= '0;
            s_if.data_out       <= '0;
            s_if.data_out_zero  <= 1'b0;
            s_if.data_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_last) begin
                    r_acc      <= '0;
                    r_beat_cnt <= '0;
                end else begin
                    r_acc      <= w_final;
                    r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                end
            end

            // A new result overrides the drain so back-to-back blocks have no bubble.
            if (w_accept && w_last) begin
                s_if.data_out       <= w_lead;
                s_if.data_out_zero  <= (w_final == '0);
                s_if.data_out_valid <= 1'b1;
            end else if (s_if.data_out_valid && s_if.data_out_ready) begin
                s_if.data_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_log2_max_abs_stream.sv
// Directed bench: 4-beat signed instance plus a 1-beat unsigned instance.
module tb_log2_max_abs_stream;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    log2_max_abs_stream_if #(.IN_SIZE(4), .IN_WIDTH(16)) a_if ();
    log2_max_abs_stream_if #(.IN_SIZE(4), .IN_WIDTH(16)) u_if ();

    log2_max_abs_stream #(
        .IN_SIZE(4), .IN_WIDTH(16), .BLOCK_BEATS(4), .SIGNED(1)
    ) dut_a (
        .clk  (clk),
        .rst  (rst),
        .s_if (a_if.slave)
    );

    log2_max_abs_stream #(
        .IN_SIZE(4), .IN_WIDTH(16), .BLOCK_BEATS(1), .SIGNED(0)
    ) dut_u (
        .clk  (clk),
        .rst  (rst),
        .s_if (u_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one beat on dut_a at a negedge and return at the negedge after it is taken.
    task automatic a_beat(input logic [15:0] v0, input logic [15:0] v1,
                          input logic [15:0] v2, input logic [15:0] v3);
        int guard;
        a_if.data_in[0] = v0;
        a_if.data_in[1] = v1;
        a_if.data_in[2] = v2;
        a_if.data_in[3] = v3;
        a_if.data_in_valid = 1'b1;
        #1;
        guard = 0;
        while (!a_if.data_in_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 50)
            chk("a_beat_timeout", 32'd0, 32'd1);
        @(negedge clk);
        a_if.data_in_valid = 1'b0;
    endtask

    task automatic u_set(input logic [15:0] v0, input logic [15:0] v1,
                         input logic [15:0] v2, input logic [15:0] v3);
        u_if.data_in[0] = v0;
        u_if.data_in[1] = v1;
        u_if.data_in[2] = v2;
        u_if.data_in[3] = v3;
        u_if.data_in_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_if.data_in[i] = '0;
            u_if.data_in[i] = '0;
        end
        a_if.data_in_valid  = 1'b0;
        a_if.data_out_ready = 1'b1;
        u_if.data_in_valid  = 1'b0;
        u_if.data_out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", a_if.data_out_valid, 1'b0);
        chk("rst_out",   a_if.data_out, 5'd0);
        chk("rst_zero",  a_if.data_out_zero, 1'b0);
        chk("rst_ready", a_if.data_in_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // Mixed-sign block: 1|2|3|4|5|7|2 = 7 -> exponent 2
        a_beat(16'd1, 16'd2, 16'd3, 16'd4);
        a_beat(16'd0, 16'd0, 16'd5, 16'd0);
        a_beat(16'hFFF9, 16'd0, 16'd0, 16'd0);
        chk("mix_pre_valid", a_if.data_out_valid, 1'b0);
        a_beat(16'd0, 16'd0, 16'd0, 16'd2);
        chk("mix_valid", a_if.data_out_valid, 1'b1);
        chk("mix_exp",   a_if.data_out, 5'd2);
        chk("mix_zero",  a_if.data_out_zero, 1'b0);
        @(negedge clk);
        chk("mix_one_cycle", a_if.data_out_valid, 1'b0);

        // Most-negative value is not saturated
        a_beat(16'd0, 16'h8000, 16'd0, 16'd0);
        a_beat(16'd0, 16'd0, 16'd0, 16'd0);
        a_beat(16'd0, 16'd0, 16'd0, 16'd0);
        a_beat(16'd0, 16'd0, 16'd0, 16'd0);
        chk("mneg_exp",  a_if.data_out, 5'd15);
        chk("mneg_zero", a_if.data_out_zero, 1'b0);

        // Signed -1 has magnitude 1
        a_beat(16'd0, 16'd0, 16'd0, 16'd0);
        a_beat(16'd0, 16'd0, 16'hFFFF, 16'd0);
        a_beat(16'd0, 16'd0, 16'd0, 16'd0);
        a_beat(16'd0, 16'd0, 16'd0, 16'd0);
        chk("neg1_exp",  a_if.data_out, 5'd0);
        chk("neg1_zero", a_if.data_out_zero, 1'b0);

        for (int b = 0; b < 4; b++)
            a_beat(16'd0, 16'd0, 16'd0, 16'd0);
        chk("zblk_valid", a_if.data_out_valid, 1'b1);
        chk("zblk_exp",   a_if.data_out, 5'd0);
        chk("zblk_zero",  a_if.data_out_zero, 1'b1);

        a_beat(16'd0, 16'd0, 16'd0, 16'd0);
        a_beat(16'd0, 16'd0, 16'd0, 16'd0);
        a_beat(16'd0, 16'd0, 16'd0, 16'd1);
        a_beat(16'd0, 16'd0, 16'd0, 16'd0);
        chk("one_exp",  a_if.data_out, 5'd0);
        chk("one_zero", a_if.data_out_zero, 1'b0);
        @(negedge clk);

        // Backpressure: block 1 max 0x10 (4), block 2 max 0x400 (10)
        a_if.data_out_ready = 1'b0;
        for (int b = 0; b < 4; b++)
            a_beat(16'h0010, 16'd0, 16'd0, 16'd0);
        chk("bp_r1_valid", a_if.data_out_valid, 1'b1);
        chk("bp_r1_exp",   a_if.data_out, 5'd4);
        for (int b = 0; b < 3; b++)
            a_beat(16'd0, 16'h0400, 16'd0, 16'd0);
        chk("bp_nonlast_taken", a_if.data_out, 5'd4);
        a_if.data_in[0] = 16'd0;
        a_if.data_in[1] = 16'd0;
        a_if.data_in[2] = 16'd3;
        a_if.data_in[3] = 16'd0;
        a_if.data_in_valid = 1'b1;
        #1;
        chk("bp_last_stall", a_if.data_in_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("bp_hold_ready", a_if.data_in_ready, 1'b0);
        chk("bp_hold_valid", a_if.data_out_valid, 1'b1);
        chk("bp_hold_exp",   a_if.data_out, 5'd4);
        a_if.data_out_ready = 1'b1;
        #1;
        chk("bp_drain_ready", a_if.data_in_ready, 1'b1);
        @(negedge clk);
        a_if.data_out_ready = 1'b0;
        a_if.data_in_valid  = 1'b0;
        chk("bp_r2_valid", a_if.data_out_valid, 1'b1);
        chk("bp_r2_exp",   a_if.data_out, 5'd10);
        a_if.data_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_r2_drained", a_if.data_out_valid, 1'b0);

        // Async reset mid-block with a result pending
        a_if.data_out_ready = 1'b0;
        for (int b = 0; b < 4; b++)
            a_beat(16'h0020, 16'd0, 16'd0, 16'd0);
        chk("ar_pre_exp", a_if.data_out, 5'd5);
        a_beat(16'h4000, 16'd0, 16'd0, 16'd0);
        a_beat(16'h4000, 16'd0, 16'd0, 16'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", a_if.data_out_valid, 1'b0);
        chk("ar_exp",   a_if.data_out, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        a_if.data_out_ready = 1'b1;
        for (int b = 0; b < 4; b++)
            a_beat(16'd0, 16'h0100, 16'd0, 16'd0);
        chk("ar_post_valid", a_if.data_out_valid, 1'b1);
        chk("ar_post_exp",   a_if.data_out, 5'd8);
        @(negedge clk);

        // Unsigned single-beat instance: no abs applied
        u_set(16'h8000, 16'd0, 16'd0, 16'd0);
        @(negedge clk);
        u_if.data_in_valid = 1'b0;
        chk("u_8000_exp",  u_if.data_out, 5'd15);
        chk("u_8000_zero", u_if.data_out_zero, 1'b0);
        u_set(16'd0, 16'd0, 16'hFFFF, 16'd0);
        @(negedge clk);
        u_if.data_in_valid = 1'b0;
        chk("u_ffff_exp", u_if.data_out, 5'd15);
        @(negedge clk);

        // Streaming: one result per cycle
        for (int k = 0; k < 8; k++) begin
            u_set(16'd0, 16'd0, 16'd0, 16'd0);
            u_if.data_in[k % 4] = 16'(1 << k);
            #1;
            chk($sformatf("stream_rdy%0d", k), u_if.data_in_ready, 1'b1);
            @(negedge clk);
            chk($sformatf("stream_vld%0d", k), u_if.data_out_valid, 1'b1);
            chk($sformatf("stream_exp%0d", k), u_if.data_out, 32'(k));
        end
        u_if.data_in_valid = 1'b0;
        @(negedge clk);
        chk("stream_end", u_if.data_out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
